// File: rtl/mod7_frame_tx.sv
// mod7_frame_tx: serializes a parallel word as 6-bit beats, MSB chunk first,
// then appends the word's mod-7 residue as a trailer beat.
module mod7_frame_tx #(
  parameter int NW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6*NW-1:0] data_in,
  input  logic            send,
  output logic            ready,
  output logic [5:0]      out_bus,
  output logic            out_valid,
  output logic            out_last,
  input  logic            out_ready,
  output logic [2:0]      res_out,
  output logic            done
);

  localparam int DW = 6 * NW;
  localparam int CW = $clog2(NW);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TRAIL
  } state_t;

  state_t        state;
  logic [DW-1:0] sr;
  logic [CW-1:0] cnt;
  logic [2:0]    r;

  logic [5:0] chunk;
  logic [2:0] c7;
  logic [2:0] r_nx;
  logic       xfer;

  // Reduce a sum of two 3-bit residues (max 14) to 0..6.
  function automatic logic [2:0] fold7(input logic [3:0] s);
    logic [3:0] t;
    if (s >= 4'd14)
      t = 4'd0;
    else if (s >= 4'd7)
      t = s - 4'd7;
    else
      t = s;
    return t[2:0];
  endfunction

  assign chunk = sr[DW-1:DW-6];
  // 8 = 1 (mod 7), so a 6-bit chunk folds as hi + lo octal digits.
  assign c7    = fold7({1'b0, chunk[5:3]} + {1'b0, chunk[2:0]});
  assign r_nx  = fold7({1'b0, r} + {1'b0, c7});

  assign ready     = (state == IDLE);
  assign out_valid = (state != IDLE);
  assign out_last  = (state == TRAIL);
  assign xfer      = out_valid & out_ready;

  // Beat selection depends only on state and registers.
  always_comb begin
    out_bus = 6'd0;
    unique case (state)
      IDLE:    out_bus = 6'd0;
      DATA:    out_bus = chunk;
      TRAIL:   out_bus = {3'b000, r};
      default: out_bus = 6'd0;
    endcase
  end

  // Frame FSM: capture, shift out chunks, emit trailer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      r       <= 3'd0;
      res_out <= 3'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (send) begin
            sr    <= data_in;
            cnt   <= '0;
            r     <= 3'd0;
            state <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            sr  <= {sr[DW-7:0], 6'd0};
            r   <= r_nx;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(NW - 1))
              state <= TRAIL;
          end
        end
        TRAIL: begin
          if (xfer) begin
            res_out <= r;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod7_frame_tx.sv
// tb_mod7_frame_tx: scoreboard bench for mod7_frame_tx (NW=8),
// directed frames with stall, ignored send and mid-frame reset.
module tb_mod7_frame_tx;

  localparam int NW = 8;
  localparam int DW = 6 * NW;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          send;
  logic          ready;
  logic [5:0]    out_bus;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic [2:0]    res_out;
  logic          done;

  mod7_frame_tx #(.NW(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .send      (send),
    .ready     (ready),
    .out_bus   (out_bus),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .res_out   (res_out),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [6:0] exp_q[$];
  logic [2:0] exp_res[$];

  task automatic chk(input string name, input logic [47:0] act,
                     input logic [47:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops expected beats on transfers, checks stall stability
  // and the completed-frame residue on done.
  logic       prev_stall = 1'b0;
  logic [5:0] prev_bus = 6'd0;
  logic       prev_last = 1'b0;

  always @(negedge clk) begin
    logic [6:0] e;
    logic [2:0] er;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 48'(out_valid), 48'd1);
        chk("stall_bus", 48'(out_bus), 48'(prev_bus));
        chk("stall_last", 48'(out_last), 48'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL beat_unexpected: got %0h, expected none",
                   {out_last, out_bus});
        end else begin
          e = exp_q.pop_front();
          chk("beat", 48'({out_last, out_bus}), 48'(e));
        end
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL done_unexpected: got res %0d, expected no done",
                   res_out);
        end else begin
          er = exp_res.pop_front();
          chk("res_out", 48'(res_out), 48'(er));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_bus   = out_bus;
      prev_last  = out_last;
    end
  end

  task automatic push_frame(input logic [DW-1:0] d);
    logic [DW-1:0] t;
    logic [2:0]    m;
    for (int i = 0; i < NW; i++) begin
      t = d >> (6 * (NW - 1 - i));
      exp_q.push_back({1'b0, t[5:0]});
    end
    m = 3'(d % 7);
    exp_q.push_back({1'b1, 3'b000, m});
    exp_res.push_back(m);
  endtask

  task automatic start(input logic [DW-1:0] d);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0, expected 1");
    end
    push_frame(d);
    send    = 1'b1;
    data_in = d;
    @(posedge clk);
    #1;
    send    = 1'b0;
    data_in = {16'($urandom), 32'($urandom)};
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done, expected done");
    end else if (exp_lat >= 0) begin
      chk("done_latency", 48'(n), 48'(exp_lat));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    send      = 1'b0;
    data_in   = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_ready", 48'(ready), 48'd1);
    chk("rst_valid", 48'(out_valid), 48'd0);
    chk("rst_last", 48'(out_last), 48'd0);
    chk("rst_bus", 48'(out_bus), 48'd0);
    chk("rst_res", 48'(res_out), 48'd0);
    chk("rst_done", 48'(done), 48'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frames, out_ready held high.
    start(48'd100);
    wait_done(NW + 1);
    start(48'hFFFF_FFFF_FFFF);
    wait_done(NW + 1);
    start(48'h8000_0000_0000);
    wait_done(NW + 1);
    start(48'h1234_5678_9ABC);
    wait_done(NW + 1);

    // Back-to-back with send held high across the trailer.
    push_frame(48'd7);
    send    = 1'b1;
    data_in = 48'd7;
    @(posedge clk);
    #1;
    data_in = 48'd13;
    push_frame(48'd13);
    wait_done(-1);
    chk("b2b_valid", 48'(out_valid), 48'd1);
    send = 1'b0;
    wait_done(-1);

    // Downstream stall during beat 3.
    start(48'd100);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_done(-1);

    // send during DATA is ignored.
    start(48'h0000_0000_002A);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("busy_ready", 48'(ready), 48'd0);
    send    = 1'b1;
    data_in = 48'hABCD_EF01_2345;
    @(posedge clk);
    #1;
    send = 1'b0;
    chk("busy_ready2", 48'(ready), 48'd0);
    wait_done(-1);
    chk("after_ready", 48'(ready), 48'd1);

    // Reset during beat 5 aborts the frame.
    start(48'd100);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_valid", 48'(out_valid), 48'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 48'(out_valid), 48'd0);
    chk("abort_ready", 48'(ready), 48'd1);
    chk("abort_res", 48'(res_out), 48'd0);
    chk("abort_last", 48'(out_last), 48'd0);
    exp_q.delete();
    exp_res.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start(48'd100);
    wait_done(NW + 1);

    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("idle_valid", 48'(out_valid), 48'd0);
    chk("q_empty", 48'(exp_q.size()), 48'd0);
    chk("res_q_empty", 48'(exp_res.size()), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
